// File: rtl/mire_writer.sv
// rtl/mire_writer.sv - Wishbone master that paints a white grid test pattern into a frame buffer
module mire_writer #(
    parameter int HDISP        = 800,
    parameter int VDISP        = 480,
    parameter int GRID_LOG2    = 4,
    parameter int YIELD_PERIOD = 64
) (
    input  logic        wshb_clk,
    input  logic        wshb_rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    output logic [3:0]  sel,
    output logic        we,
    output logic        cyc,
    output logic        stb,
    input  logic        ack,
    output logic [2:0]  cti,
    output logic [1:0]  bte
);
    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int CW = $clog2(YIELD_PERIOD + 1);
    localparam logic [31:0] GRID_MASK = 32'((1 << GRID_LOG2) - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_YIELD, S_DONE} state_t;

    state_t          r_state;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [CW-1:0]   r_yield;
    logic [31:0]     r_adr;
    logic [31:0]     r_dat;
    logic [3:0]      r_sel;
    logic            r_we;
    logic            r_cyc;
    logic            r_stb;
    logic            r_busy;
    logic            r_done;

    logic            w_last_x;
    logic            w_last_pix;
    logic            w_yield_hit;
    logic [XW-1:0]   w_nx;
    logic [YW-1:0]   w_ny;

    function automatic logic [31:0] grid_color(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (((32'(x) & GRID_MASK) == 32'd0) || ((32'(y) & GRID_MASK) == 32'd0))
               ? 32'h00FF_FFFF : 32'h0000_0000;
    endfunction

    assign w_last_x    = (r_x == XW'(HDISP - 1));
    assign w_last_pix  = w_last_x && (r_y == YW'(VDISP - 1));
    assign w_nx        = w_last_x ? '0 : r_x + 1'b1;
    assign w_ny        = w_last_x ? r_y + 1'b1 : r_y;
    assign w_yield_hit = (CW'(r_yield + 1'b1) == CW'(YIELD_PERIOD));

    // Address advances linearly by one word per accepted write, which equals 4*(y*HDISP+x).
    always_ff @(posedge wshb_clk) begin
        if (wshb_rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_yield <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_WRITE;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_yield <= '0;
                        r_adr   <= '0;
                        r_dat   <= grid_color('0, '0);
                        r_sel   <= 4'b0111;
                        r_we    <= 1'b1;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (ack) begin
                        r_x   <= w_nx;
                        r_y   <= w_ny;
                        r_adr <= r_adr + 32'd4;
                        r_dat <= grid_color(w_nx, w_ny);
                        if (w_last_pix) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_sel   <= '0;
                            r_we    <= 1'b0;
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                        end else if (w_yield_hit) begin
                            r_state <= S_YIELD;
                            r_yield <= '0;
                            r_sel   <= '0;
                            r_we    <= 1'b0;
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                        end else begin
                            r_yield <= r_yield + 1'b1;
                        end
                    end
                end
                S_YIELD: begin
                    r_state <= S_WRITE;
                    r_sel   <= 4'b0111;
                    r_we    <= 1'b1;
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign adr    = r_adr;
    assign dat_ms = r_dat;
    assign sel    = r_sel;
    assign we     = r_we;
    assign cyc    = r_cyc;
    assign stb    = r_stb;
    assign cti    = 3'b000;
    assign bte    = 2'b00;
endmodule

// File: doc/mire_writer.md
MIRE_WRITER -- requirements
Module: mire_writer

Interface
REQ-001 The block SHALL have parameter HDISP, default 800, meaning active pixels per line.
REQ-002 The block SHALL have parameter VDISP, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter GRID_LOG2, default 4, meaning grid pitch = 2**GRID_LOG2 pixels.
REQ-004 The block SHALL have parameter YIELD_PERIOD, default 64, meaning accepted writes between bus releases (≥1).
REQ-005 The block SHALL have port wshb_clk, input, 1 bit, the single clock of the block.
REQ-006 The block SHALL have port wshb_rst, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit, request to fill one frame.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a fill is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, one-cycle pulse at fill completion.
REQ-010 The block SHALL have port adr, output, 32 bits, Wishbone byte address.
REQ-011 The block SHALL have port dat_ms, output, 32 bits, Wishbone write data.
REQ-012 The block SHALL have ports sel (output, 4 bits), we (output, 1 bit), cyc (output, 1 bit) and stb (output, 1 bit), with Wishbone classic meaning.
REQ-013 The block SHALL have port ack, input, 1 bit, Wishbone slave acknowledge.
REQ-014 The block SHALL have ports cti (output, 3 bits) and bte (output, 2 bits), both tied to 0.

Function
REQ-015 The block SHALL implement states IDLE, WRITE, YIELD and DONE.
REQ-016 IDLE SHALL hold cyc=0, stb=0 and busy=0, and SHALL move to WRITE on start=1, clearing the counters x=0, y=0 and the yield counter.
REQ-017 In WRITE, cyc, stb and we SHALL be 1 and sel SHALL be 4'b0111.
REQ-018 In WRITE, adr SHALL equal 4*(y*HDISP + x), computed in 32-bit unsigned arithmetic.
REQ-019 dat_ms SHALL be 32'h00FFFFFF when x[GRID_LOG2-1:0]==0 or y[GRID_LOG2-1:0]==0, and 32'h00000000 otherwise; bits 31:24 SHALL always be 0.
REQ-020 adr and dat_ms SHALL stay stable while stb=1 and ack=0; the block SHALL wait any number of cycles for ack.
REQ-021 On each cycle with stb=1 and ack=1, x SHALL increment; when x==HDISP-1, x SHALL wrap to 0 and y SHALL increment.
REQ-022 After the ack for x=HDISP-1, y=VDISP-1, the state SHALL go to DONE regardless of the yield count.
REQ-023 Otherwise, on the ack that makes the accepted-write count reach YIELD_PERIOD, the state SHALL go to YIELD and the count SHALL clear.
REQ-024 YIELD SHALL last exactly one cycle with cyc=0 and stb=0, then return to WRITE with counters unchanged.
REQ-025 DONE SHALL last one cycle with done=1, cyc=0 and stb=0, then go to IDLE.
REQ-026 busy SHALL be 1 in WRITE, YIELD and DONE.
REQ-027 start SHALL be ignored outside IDLE; start held high in IDLE after DONE SHALL begin a new fill.
REQ-028 ack received while stb=0 SHALL be ignored.

Reset
REQ-029 While wshb_rst=1, the block SHALL go to IDLE, clear x, y and the yield count, and drive cyc=0, stb=0, we=0, done=0, busy=0, adr=0 and dat_ms=0.
REQ-030 Reset asserted mid-fill SHALL abandon the transfer in the same clock edge, and the fill SHALL NOT resume after reset.

Verification
REQ-031 Bench case (HDISP=32, VDISP=4, GRID_LOG2=4, YIELD_PERIOD=64, ack always 1): pulse start -> 128 writes at adr 0x000..0x1FC step 4; x=0 gives 0x00FFFFFF, x=5 gives 0; done pulses once, one cycle after the last ack.
REQ-032 Bench case (same parameters, YIELD_PERIOD=8): fill -> cyc=0 for exactly one cycle after every 8th ack, except after the final ack, where DONE follows instead.
REQ-033 Bench case (random ack stalls of 0-5 cycles): fill -> adr and dat_ms stable during each stall; no write skipped or duplicated; 128 writes total.
REQ-034 Bench case (start pulsed while busy=1): fill -> no restart; exactly one done pulse per accepted start.
REQ-035 Bench case (wshb_rst asserted at write 50, then released): fill -> next cycle cyc=0 and busy=0; the following start begins again at adr 0.
REQ-036 Bench case (HDISP=800, VDISP=480, default parameters): fill -> last write at adr 0x0017_6FFC with data 0x00000000; 384000 acks in total.
